// File: rtl/jtkcpu_stkdp.sv
// ---------------------------------------------------------------------------
// jtkcpu_stkdp -- stack datapath for the jtkcpu push/pull sequencer.
//
// Moves one stack byte per cen cycle. It owns the S and U stack pointers,
// turns the sequencer's remaining-register mask into the current register,
// drives the stack bus for pushes and gathers pulled bytes into
// register-load strobes.
//
// Optional feature (compile-time macro JTKCPU_STKLIM_EN):
//   defined   -> stk_ovf is set, and stays set until reset, whenever a push
//                moves S below SLIM.
//   undefined -> stk_ovf is tied low and SLIM is unused.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   cen                clock enable, one stack byte per enabled cycle
//   psh_sel[7:0]       remaining register mask (b0 CC, b1 A, b2 B, b3 DP,
//                      b4 X, b5 Y, b6 other pointer, b7 PC)
//   hihalf             0 = first byte of a 16-bit register, 1 = second byte
//   pul_en, psh_dec    pull / push operation active
//   us_sel             0 = stack on S, 1 = stack on U
//   psh_bit[7:0]       one-hot current register (combinational)
//   cc,a,b,dp,x,y,pc   register values to push
//   s_ld,u_ld,ptr_din  idle-time pointer loads
//   din[7:0]           memory read data for the presented addr
//   addr,dout,we       stack bus
//   s,u                current pointers
//   pul_wr,pul_dst,    one-clk register-load strobe, destination (one-hot)
//   pul_data             and value (8-bit registers zero-extended)
//   stk_ovf            sticky S underflow flag
//
// Strobe semantics: we is asserted only in cycles where cen=1 and a push is
// active, so every we-high clock edge is exactly one committed byte write.
// pul_wr is a single-clk pulse carrying pul_dst/pul_data; there is no
// back-pressure, the register file must accept it on that clk.
// ---------------------------------------------------------------------------
module jtkcpu_stkdp #(
  parameter logic [15:0] SLIM = 16'h0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic [7:0]  psh_sel,
  input  logic        hihalf,
  input  logic        pul_en,
  input  logic        psh_dec,
  input  logic        us_sel,
  output logic [7:0]  psh_bit,
  input  logic [7:0]  cc,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [7:0]  dp,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] pc,
  input  logic        s_ld,
  input  logic        u_ld,
  input  logic [15:0] ptr_din,
  input  logic [7:0]  din,
  output logic [15:0] addr,
  output logic [7:0]  dout,
  output logic        we,
  output logic [15:0] s,
  output logic [15:0] u,
  output logic        pul_wr,
  output logic [7:0]  pul_dst,
  output logic [15:0] pul_data,
  output logic        stk_ovf
);

  logic        pull;
  logic        push;
  logic        is_wide;
  logic [15:0] ptr;
  logic [15:0] other_ptr;
  logic [15:0] ptr_dec;
  logic [15:0] ptr_inc;
  logic [15:0] wide_val;
  logic [7:0]  narrow_val;
  logic [7:0]  push_byte;
  logic [7:0]  hi_latch;
  logic [15:0] pull_word;

  // A pull with nothing left to transfer is treated as idle, which also
  // lets a push request through in that case.
  assign pull = pul_en & (psh_sel != 8'h00);
  assign push = psh_dec & ~pull;

  // Pulls unstack in ascending register order, pushes in descending order,
  // so the pull picks the lowest set bit and everything else the highest.
  always_comb begin
    psh_bit = 8'h00;
    if (pull) begin
      for (int i = 7; i >= 0; i--) begin
        if (psh_sel[i]) begin
          psh_bit    = 8'h00;
          psh_bit[i] = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (psh_sel[i]) begin
          psh_bit    = 8'h00;
          psh_bit[i] = 1'b1;
        end
      end
    end
  end

  assign is_wide   = |psh_bit[7:4];
  assign ptr       = us_sel ? u : s;
  // Bit 6 names the pointer that is not being used as the stack.
  assign other_ptr = us_sel ? s : u;
  assign ptr_dec   = ptr - 16'd1;
  assign ptr_inc   = ptr + 16'd1;

  always_comb begin
    wide_val = 16'h0000;
    if (psh_bit[4])      wide_val = x;
    else if (psh_bit[5]) wide_val = y;
    else if (psh_bit[6]) wide_val = other_ptr;
    else if (psh_bit[7]) wide_val = pc;
  end

  always_comb begin
    narrow_val = 8'h00;
    if (psh_bit[0])      narrow_val = cc;
    else if (psh_bit[1]) narrow_val = a;
    else if (psh_bit[2]) narrow_val = b;
    else if (psh_bit[3]) narrow_val = dp;
  end

  // Pushes go low byte first so that the high byte ends up at the lower
  // address (big-endian frame).
  assign push_byte = is_wide ? (hihalf ? wide_val[15:8] : wide_val[7:0])
                             : narrow_val;

  assign addr      = push ? ptr_dec : ptr;
  assign dout      = push ? push_byte : 8'h00;
  assign we        = push & cen;
  assign pull_word = {hi_latch, din};

  always_ff @(posedge clk) begin
    if (rst) begin
      s        <= 16'h0000;
      u        <= 16'h0000;
      pul_wr   <= 1'b0;
      pul_dst  <= 8'h00;
      pul_data <= 16'h0000;
      hi_latch <= 8'h00;
    end else begin
      // One-clk pulse regardless of cen.
      pul_wr <= 1'b0;
      if (cen) begin
        if (push) begin
          if (us_sel) u <= ptr_dec;
          else        s <= ptr_dec;
        end else if (pull) begin
          if (us_sel) u <= ptr_inc;
          else        s <= ptr_inc;
          if (!is_wide) begin
            pul_data <= {8'h00, din};
            pul_dst  <= psh_bit;
            pul_wr   <= 1'b1;
          end else if (!hihalf) begin
            hi_latch <= din;
          end else begin
            pul_data <= pull_word;
            pul_dst  <= psh_bit;
            pul_wr   <= 1'b1;
            // The other pointer lives here, so it is reloaded directly.
            if (psh_bit[6]) begin
              if (us_sel) s <= pull_word;
              else        u <= pull_word;
            end
          end
        end else begin
          if (s_ld) s <= ptr_din;
          if (u_ld) u <= ptr_din;
        end
      end
    end
  end

`ifdef JTKCPU_STKLIM_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (cen && push && !us_sel && (ptr_dec < SLIM)) begin
      ovf_q <= 1'b1;
    end
  end

  assign stk_ovf = ovf_q;
`else
  logic unused_slim;

  assign unused_slim = ^SLIM;
  assign stk_ovf     = 1'b0;
`endif

endmodule

// File: tb/tb_jtkcpu_stkdp.sv
module tb_jtkcpu_stkdp;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic [7:0]  psh_sel;
  logic        hihalf;
  logic        pul_en;
  logic        psh_dec;
  logic        us_sel;
  logic [7:0]  psh_bit;
  logic [7:0]  cc, a, b, dp;
  logic [15:0] x, y, pc;
  logic        s_ld, u_ld;
  logic [15:0] ptr_din;
  logic [7:0]  din;
  logic [15:0] addr;
  logic [7:0]  dout;
  logic        we;
  logic [15:0] s, u;
  logic        pul_wr;
  logic [7:0]  pul_dst;
  logic [15:0] pul_data;
  logic        stk_ovf;

  always #5 clk = ~clk;

  jtkcpu_stkdp dut (
    .clk(clk), .rst(rst), .cen(cen), .psh_sel(psh_sel), .hihalf(hihalf),
    .pul_en(pul_en), .psh_dec(psh_dec), .us_sel(us_sel), .psh_bit(psh_bit),
    .cc(cc), .a(a), .b(b), .dp(dp), .x(x), .y(y), .pc(pc),
    .s_ld(s_ld), .u_ld(u_ld), .ptr_din(ptr_din), .din(din),
    .addr(addr), .dout(dout), .we(we), .s(s), .u(u),
    .pul_wr(pul_wr), .pul_dst(pul_dst), .pul_data(pul_data), .stk_ovf(stk_ovf)
  );

  // ---------------- memory and bus monitors ----------------
  logic [7:0]  mem [0:65535];
  logic [23:0] wr_q[$];       // observed {addr, data} writes
  logic [23:0] pul_q[$];      // observed {dst, data} pull strobes
  logic [23:0] exp_q[$];      // expected writes
  logic [23:0] exp_pul_q[$];  // expected pull strobes

  assign din = mem[addr];

  always @(posedge clk) begin
    if (we) begin
      mem[addr] <= dout;
      wr_q.push_back({addr, dout});
    end
  end

  always @(negedge clk) begin
    if (pul_wr) pul_q.push_back({pul_dst, pul_data});
  end

  // ---------------- reference model state ----------------
  logic [15:0] m_s, m_u;
  logic        m_ovf;
  int          n_pass  = 0;
  int          n_total = 0;

  // Register the sequencer is working on: pulls take registers in ascending
  // order, pushes in descending order.
  function automatic logic [7:0] model_bit(input logic [7:0] sel, input bit is_pull);
    logic [7:0] r;
    r = 8'h00;
    if (sel != 8'h00) begin
      if (is_pull) begin
        for (int i = 0; i < 8; i++) if (sel[i] && r == 8'h00) r = 8'(1 << i);
      end else begin
        for (int i = 7; i >= 0; i--) if (sel[i] && r == 8'h00) r = 8'(1 << i);
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] reg_val(input int i, input logic [15:0] other);
    case (i)
      0: return {8'h00, cc};
      1: return {8'h00, a};
      2: return {8'h00, b};
      3: return {8'h00, dp};
      4: return x;
      5: return y;
      6: return other;
      default: return pc;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic go_idle();
    psh_sel = 8'h00; hihalf = 1'b0; pul_en = 1'b0; psh_dec = 1'b0;
    s_ld = 1'b0; u_ld = 1'b0; cen = 1'b1;
  endtask

  task automatic rand_regs();
    cc = 8'($urandom); a = 8'($urandom); b = 8'($urandom); dp = 8'($urandom);
    x = 16'($urandom); y = 16'($urandom); pc = 16'($urandom);
  endtask

  task automatic load_ptrs(input bit ls, input bit lu, input logic [15:0] v);
    @(negedge clk);
    go_idle();
    s_ld = ls; u_ld = lu; ptr_din = v;
    @(negedge clk);
    go_idle();
    if (ls) m_s = v;
    if (lu) m_u = v;
  endtask

  // Acts as the push/pull sequencer: walks the mask one byte per cen cycle.
  task automatic run_seq(input logic [7:0] mask, input bit is_pull, input bit usel,
                         input bit rnd_cen, input bit hold_ld);
    logic [7:0] sel;
    logic [7:0] eb;
    bit         hi;
    int         guard;
    sel = mask; hi = 1'b0; guard = 0;
    while (sel != 8'h00 && guard < 200) begin
      @(negedge clk);
      psh_sel = sel; hihalf = hi; pul_en = is_pull; psh_dec = !is_pull;
      us_sel = usel; s_ld = hold_ld; ptr_din = 16'h3000;
      cen = rnd_cen ? ($urandom_range(0, 3) != 0) : 1'b1;
      eb = model_bit(sel, is_pull);
      #1;
      n_total++;
      if (psh_bit !== eb) $display("FAIL psh_bit: got %h want %h (sel %h)", psh_bit, eb, sel);
      else n_pass++;
      @(posedge clk);
      if (cen) begin
        if (eb[7:4] != 4'h0 && !hi) hi = 1'b1;
        else begin sel = sel & ~eb; hi = 1'b0; end
      end
      guard++;
    end
    @(negedge clk);
    go_idle();
    #1;
    n_total++;
    if (guard >= 200) $display("FAIL seq_budget: got %0d cycles want <200", guard);
    else n_pass++;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_push_op(input logic [7:0] mask, input bit usel, input bit rnd_cen);
    logic [15:0] p, v;
    logic [23:0] got, want;
    p = usel ? m_u : m_s;
    exp_q.delete(); wr_q.delete();
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) begin
        v = reg_val(i, usel ? m_s : m_u);
        p = p - 16'd1; exp_q.push_back({p, v[7:0]});
`ifdef JTKCPU_STKLIM_EN
        if (!usel && p < 16'h0100) m_ovf = 1'b1;
`endif
        if (i >= 4) begin
          p = p - 16'd1; exp_q.push_back({p, v[15:8]});
`ifdef JTKCPU_STKLIM_EN
          if (!usel && p < 16'h0100) m_ovf = 1'b1;
`endif
        end
      end
    end
    if (usel) m_u = p; else m_s = p;
    run_seq(mask, 1'b0, usel, rnd_cen, 1'b0);
    n_total++;
    if (wr_q.size() != exp_q.size()) $display("FAIL push_count: got %0d want %0d", wr_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = (wr_q.size() > 0) ? wr_q.pop_front() : 24'hxxxxxx;
      n_total++;
      if (got !== want) $display("FAIL push_write: got %h@%h want %h@%h", got[7:0], got[23:8], want[7:0], want[23:8]);
      else n_pass++;
    end
    n_total++;
    if (s !== m_s || u !== m_u) $display("FAIL push_ptrs: got s=%h u=%h want s=%h u=%h", s, u, m_s, m_u);
    else n_pass++;
    n_total++;
    if (stk_ovf !== m_ovf) $display("FAIL push_ovf: got %b want %b", stk_ovf, m_ovf);
    else n_pass++;
  endtask

  task automatic test_pull_op(input logic [7:0] mask, input bit usel, input bit rnd_cen, input bit hold_ld);
    logic [15:0] p, v, other;
    logic [23:0] got, want;
    p = usel ? m_u : m_s;
    other = usel ? m_s : m_u;
    exp_pul_q.delete(); pul_q.delete();
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        if (i >= 4) begin
          v = {mem[p], mem[16'(p + 16'd1)]};
          p = p + 16'd2;
          if (i == 6) other = v;
        end else begin
          v = {8'h00, mem[p]};
          p = p + 16'd1;
        end
        exp_pul_q.push_back({8'(1 << i), v});
      end
    end
    if (usel) begin m_u = p; m_s = other; end
    else      begin m_s = p; m_u = other; end
    run_seq(mask, 1'b1, usel, rnd_cen, hold_ld);
    n_total++;
    if (pul_q.size() != exp_pul_q.size()) $display("FAIL pull_count: got %0d want %0d", pul_q.size(), exp_pul_q.size());
    else n_pass++;
    while (exp_pul_q.size() > 0) begin
      want = exp_pul_q.pop_front();
      got  = (pul_q.size() > 0) ? pul_q.pop_front() : 24'hxxxxxx;
      n_total++;
      if (got !== want) $display("FAIL pull_strobe: got dst=%h data=%h want dst=%h data=%h", got[23:16], got[15:0], want[23:16], want[15:0]);
      else n_pass++;
    end
    n_total++;
    if (s !== m_s || u !== m_u) $display("FAIL pull_ptrs: got s=%h u=%h want s=%h u=%h", s, u, m_s, m_u);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; go_idle(); us_sel = 1'b0; ptr_din = 16'h0000;
    rand_regs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_s = 16'h0000; m_u = 16'h0000; m_ovf = 1'b0;
    #1;
    n_total++;
    if (s !== 16'h0000 || u !== 16'h0000) $display("FAIL reset_ptrs: got s=%h u=%h want 0000", s, u);
    else n_pass++;
    n_total++;
    if (pul_wr !== 1'b0 || pul_dst !== 8'h00 || pul_data !== 16'h0000)
      $display("FAIL reset_pul: got wr=%b dst=%h data=%h want 0", pul_wr, pul_dst, pul_data);
    else n_pass++;
    n_total++;
    if (we !== 1'b0 || stk_ovf !== 1'b0 || addr !== 16'h0000 || dout !== 8'h00)
      $display("FAIL reset_bus: got we=%b ovf=%b addr=%h dout=%h want 0", we, stk_ovf, addr, dout);
    else n_pass++;
  endtask

  task automatic test_push_basic();
    load_ptrs(1'b1, 1'b0, 16'h1000);
    rand_regs(); pc = 16'hABCD; cc = 8'h5A;
    test_push_op(8'h81, 1'b0, 1'b0);
    n_total++;
    if (s !== 16'h0FFD || mem[16'h0FFF] !== 8'hCD || mem[16'h0FFE] !== 8'hAB || mem[16'h0FFD] !== 8'h5A)
      $display("FAIL push_basic: got s=%h mem=%h %h %h want 0FFD CD AB 5A", s,
               mem[16'h0FFF], mem[16'h0FFE], mem[16'h0FFD]);
    else n_pass++;
  endtask

  task automatic test_pull_frame();
    load_ptrs(1'b1, 1'b1, 16'h1000);
    load_ptrs(1'b0, 1'b1, 16'h7E21);
    rand_regs();
    test_push_op(8'hFF, 1'b0, 1'b0);
    load_ptrs(1'b0, 1'b1, 16'hDEAD);
    rand_regs();
    test_pull_op(8'hFF, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (s !== 16'h1000 || u !== 16'h7E21) $display("FAIL pull_frame: got s=%h u=%h want 1000 7E21", s, u);
    else n_pass++;
  endtask

  task automatic test_push_u();
    load_ptrs(1'b1, 1'b0, 16'h1234);
    load_ptrs(1'b0, 1'b1, 16'h2000);
    test_push_op(8'h40, 1'b1, 1'b0);
    n_total++;
    if (u !== 16'h1FFE || s !== 16'h1234 || mem[16'h1FFF] !== 8'h34 || mem[16'h1FFE] !== 8'h12)
      $display("FAIL push_u: got u=%h s=%h mem=%h %h want 1FFE 1234 34 12", u, s, mem[16'h1FFF], mem[16'h1FFE]);
    else n_pass++;
  endtask

  task automatic test_wrap();
    load_ptrs(1'b1, 1'b0, 16'h0001);
    rand_regs();
    test_push_op(8'h06, 1'b0, 1'b0);
    n_total++;
    if (s !== 16'hFFFF) $display("FAIL wrap_s: got %h want FFFF", s);
    else n_pass++;
    test_pull_op(8'h06, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (s !== 16'h0001) $display("FAIL wrap_back: got %h want 0001", s);
    else n_pass++;
  endtask

  task automatic test_ld_ignored();
    load_ptrs(1'b1, 1'b0, 16'h0800);
    test_pull_op(8'h13, 1'b0, 1'b0, 1'b1);
    n_total++;
    if (s !== 16'h0804) $display("FAIL ld_ignored: got %h want 0804", s);
    else n_pass++;
    load_ptrs(1'b1, 1'b0, 16'h3000);
    n_total++;
    if (s !== 16'h3000) $display("FAIL ld_idle: got %h want 3000", s);
    else n_pass++;
    load_ptrs(1'b1, 1'b1, 16'h4567);
    n_total++;
    if (s !== 16'h4567 || u !== 16'h4567) $display("FAIL ld_both: got s=%h u=%h want 4567", s, u);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] mask;
    bit         usel;
    for (int k = 0; k < 12; k++) begin
      load_ptrs(1'b1, 1'b0, 16'($urandom_range(16'h0400, 16'hF000)));
      load_ptrs(1'b0, 1'b1, 16'($urandom_range(16'h0400, 16'hF000)));
      mask = 8'($urandom_range(1, 255));
      usel = 1'($urandom_range(0, 1));
      rand_regs();
      test_push_op(mask, usel, 1'b1);
      rand_regs();
      test_pull_op(mask, usel, 1'b1, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    load_ptrs(1'b1, 1'b1, 16'h0500);
    pul_q.delete();
    @(negedge clk);
    psh_sel = 8'h10; hihalf = 1'b0; pul_en = 1'b1; psh_dec = 1'b0; us_sel = 1'b0; cen = 1'b1;
    @(negedge clk);
    hihalf = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; go_idle();
    m_s = 16'h0000; m_u = 16'h0000; m_ovf = 1'b0;
    #1;
    n_total++;
    if (s !== 16'h0000 || u !== 16'h0000 || stk_ovf !== 1'b0 || we !== 1'b0)
      $display("FAIL reset_mid: got s=%h u=%h ovf=%b we=%b want 0", s, u, stk_ovf, we);
    else n_pass++;
    repeat (3) @(negedge clk);
    #1;
    n_total++;
    if (pul_q.size() != 0) $display("FAIL reset_mid_pul: got %0d strobes want 0", pul_q.size());
    else n_pass++;
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_push_basic();
    test_pull_frame();
    test_push_u();
    test_wrap();
    test_ld_ignored();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/jtkcpu_stkdp.md
Name: jtkcpu_stkdp

Overview:
Stack datapath that executes the byte transfers requested by the push/pull sequencer.
- Owns the S and U stack pointers.
- Resolves the current register bit from psh_sel and drives the stack address, write data and write strobe.
- Assembles pulled bytes into register-load strobes for the register file.
- Sits between the push/pull sequencer and the bus/register file in jtkcpu.

Parameters:
SLIM, 16'h0100, lowest legal S address; used only when JTKCPU_STKLIM_EN is defined.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active high
cen  in  1  clock enable; one stack byte per cen cycle
psh_sel  in  8  remaining register mask from sequencer (b0 CC, b1 A, b2 B, b3 DP, b4 X, b5 Y, b6 U/S, b7 PC)
hihalf  in  1  0 = first byte of a 16-bit register, 1 = second byte
pul_en  in  1  pull operation active
psh_dec  in  1  push operation active (already gated by sequencer busy)
us_sel  in  1  0 = operate on S, 1 = operate on U
psh_bit  out  8  one-hot current register, fed back to sequencer
cc, a, b, dp  in  8  register values to push
x, y, pc  in  16  register values to push
s_ld, u_ld  in  1  load S / U from ptr_din
ptr_din  in  16  pointer load value
din  in  8  memory read data, valid in the cycle addr is presented
addr  out  16  stack access address
dout  out  8  stack write data
we  out  1  write strobe
s, u  out  16  current pointers
pul_wr  out  1  one-clk strobe: pul_data valid for pul_dst
pul_dst  out  8  one-hot destination register of pul_wr
pul_data  out  16  pulled value; 8-bit registers zero-extended
stk_ovf  out  1  sticky S underflow flag (optional feature)

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - Registers: s=u=0, pul_wr=0, pul_dst=0, pul_data=0, internal hi latch=0, stk_ovf=0.
  - Outputs: we=0 from reset onward.
- Active: pull = pul_en & psh_sel!=0; push = psh_dec & !pull.
- Bit resolution:
  - psh_bit is combinational.
  - Pull selects the lowest set bit of psh_sel; otherwise the highest set bit.
  - psh_sel=0 gives 0.
- 16-bit registers: bits 4-7. Bit 6 is the *other* pointer: U when us_sel=0, S when us_sel=1.
- Active pointer P = us_sel ? u : s.
- Push byte (combinational for the cycle):
  - addr = P-1.
  - dout: 8-bit register value; or 16-bit low byte when hihalf=0, high byte when hihalf=1.
  - we = push & cen.
  - On the cen edge, P <= P-1.
- Pull byte:
  - addr = P; we=0; on the cen edge, P <= P+1.
  - 8-bit register: at the cen edge, pul_data <= {8'h00,din}, pul_dst <= psh_bit, pul_wr <= 1.
  - 16-bit register, hihalf=0: hi latch <= din, no strobe.
  - 16-bit register, hihalf=1: pul_data <= {latch,din}, pul_dst <= psh_bit, pul_wr <= 1.
- pul_wr is high for exactly one clk after the capturing edge, then 0, independent of cen.
- Pull into the other pointer: this block loads it from {latch,din} on the same edge that asserts pul_wr (pul_dst=8'h40 is still emitted).
- Idle (no push/pull): addr = P, dout = 0, pointers hold.
- Pointer arithmetic is 16-bit modulo: 0000-1 = FFFF, FFFF+1 = 0000.
- s_ld/u_ld take effect on the clk edge with cen=1 only when neither push nor pull is active; while active they are ignored. If both are asserted together, both pointers load ptr_din.
- Latency: zero-cycle address/data per byte; pull results one clk after the final byte's edge.
- Reset mid-operation:
  - Pointer state is discarded and pul_wr is cleared on the same edge.
  - A partial 16-bit pull never emits pul_wr.

Optional Feature:
JTKCPU_STKLIM_EN:
- Defined: on any cen edge where S is decremented to a value < SLIM, stk_ovf <= 1. It stays set until reset; the push still completes normally.
- Undefined: stk_ovf is tied 0 and SLIM is unused.

Test Plan:
1. s=1000, us_sel=0, push mask 81 (PC=ABCD, CC=5A) → writes CD@0FFF, AB@0FFE, 5A@0FFD; s=0FFD; we exactly 3 cen cycles.
2. s=0FF4, pull mask FF with memory holding a push-all frame → pul_wr strobes in order CC, A, B, DP, X, Y, U, PC with correct {hi,lo}; u reloaded; s=1000.
3. us_sel=1, u=2000, push mask 40 with s=1234 → 34@1FFF, 12@1FFE; u=1FFE; s unchanged.
4. s=0001, push mask 06 → writes at 0000 then FFFF; s=FFFF; with JTKCPU_STKLIM_EN, SLIM=0100: stk_ovf=1 after first byte.
5. s_ld=1, ptr_din=3000 during an active pull → ignored; after psh_sel=0, same load → s=3000.
6. rst asserted after first byte of a 16-bit pull → no pul_wr, s=u=0, stk_ovf=0, we=0.
